// File: rtl/img_grad_stream_if.sv
// Image-read / gradient-write bus for img_grad_stream.
// grad_mag is present only when IMG_GRAD_MAG_EN is defined.
interface img_grad_stream_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 16
);
  localparam int CW = PIX_W + 2;
  localparam int GW = 2 * CW;

  logic              start;
  logic              busy;
  logic              done;
  logic              img_rd;
  logic [ADDR_W-1:0] img_addr;
  logic [PIX_W-1:0]  img_di;
  logic              grad_wr;
  logic [ADDR_W-1:0] grad_addr;
  logic [GW-1:0]     grad_do;
`ifdef IMG_GRAD_MAG_EN
  logic [PIX_W:0]    grad_mag;
`endif

  modport master (
    input  start,
    input  img_di,
    output busy,
    output done,
    output img_rd,
    output img_addr,
    output grad_wr,
    output grad_addr,
    output grad_do
`ifdef IMG_GRAD_MAG_EN
    ,
    output grad_mag
`endif
  );

  modport slave (
    output start,
    output img_di,
    input  busy,
    input  done,
    input  img_rd,
    input  img_addr,
    input  grad_wr,
    input  grad_addr,
    input  grad_do
`ifdef IMG_GRAD_MAG_EN
    ,
    input  grad_mag
`endif
  );
endinterface

// File: rtl/img_grad_stream.sv
// Streaming forward-gradient engine using a one-row line buffer.
// Optional |Gx|+|Gy| output enabled by IMG_GRAD_MAG_EN.
module img_grad_stream #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  img_grad_stream_if.master  bus
);
  localparam int CW   = PIX_W + 2;
  localparam int GW   = 2 * CW;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] pix_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic [XW-1:0]     out_x;
  logic              rd_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_q;
  logic [ADDR_W-1:0] wa_q;
  logic [GW-1:0]     do_q;
  logic [PIX_W-1:0]  lb [IMG_W];

  logic start_ok;
  logic img_rd;
  logic emit_rd;
  logic emit_fl;
  logic emit;
  logic last_rd;
  logic last_out;
  logic x_last;
  logic [CW-1:0] gx;
  logic [CW-1:0] gy;

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    img_rd   = 1'b0;
    emit_fl  = 1'b0;
    last_rd  = (rd_cnt == ADDR_W'(NPIX - 1));
    last_out = (out_cnt == ADDR_W'(NPIX - 1));
    emit_rd  = rd_q && (pix_cnt >= ADDR_W'(IMG_W));
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = READ;
        end
      end
      READ: begin
        img_rd = 1'b1;
        if (last_rd) state_d = FLUSH;
      end
      FLUSH: begin
        // Last row drains once the final sample has landed.
        emit_fl = !rd_q;
        if (emit_fl && last_out) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    emit = emit_rd | emit_fl;
  end

  always_comb begin
    x_last = (out_x == XW'(IMG_W - 1));
    gx = '0;
    gy = '0;
    if (!x_last) gx = {2'b00, lb[1]} - {2'b00, lb[0]};
    if (emit_rd) gy = {2'b00, bus.img_di} - {2'b00, lb[0]};
  end

`ifdef IMG_GRAD_MAG_EN
  logic [CW-1:0]  ax;
  logic [CW-1:0]  ay;
  logic [CW-1:0]  sum;
  logic [PIX_W:0] mag;
  logic [PIX_W:0] mag_q;

  always_comb begin
    ax  = gx[CW-1] ? -gx : gx;
    ay  = gy[CW-1] ? -gy : gy;
    sum = ax + ay;
    mag = sum[CW-1] ? '1 : sum[PIX_W:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mag_q <= '0;
    else if (emit) mag_q <= mag;
  end

  assign bus.grad_mag = mag_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt  <= '0;
      pix_cnt <= '0;
      out_cnt <= '0;
      out_x   <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      wa_q    <= '0;
      do_q    <= '0;
      for (int i = 0; i < IMG_W; i++) lb[i] <= '0;
    end else begin
      if (start_ok) begin
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        rd_cnt  <= '0;
        pix_cnt <= '0;
        out_cnt <= '0;
        out_x   <= '0;
      end
      if (state_q == DONE) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
      if (img_rd) rd_cnt <= last_rd ? '0 : rd_cnt + 1'b1;
      rd_q <= img_rd;
      if (rd_q) pix_cnt <= pix_cnt + 1'b1;
      if (rd_q || emit_fl) begin
        for (int i = 0; i < IMG_W - 1; i++) lb[i] <= lb[i+1];
        lb[IMG_W-1] <= rd_q ? bus.img_di : '0;
      end
      wr_q <= emit;
      if (emit) begin
        wa_q    <= out_cnt;
        do_q    <= {gx, gy};
        out_cnt <= out_cnt + 1'b1;
        out_x   <= x_last ? '0 : out_x + 1'b1;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.img_rd    = img_rd;
  assign bus.img_addr  = rd_cnt;
  assign bus.grad_wr   = wr_q;
  assign bus.grad_addr = wa_q;
  assign bus.grad_do   = do_q;
endmodule

// File: doc/img_grad_stream.md
Name: img_grad_stream

Overview:
- Streaming successor to the single-shot image-gradient engine.
- Reads a raster image of IMG_W x IMG_H pixels of PIX_W bits from image memory, one pixel per cycle.
- Computes the forward gradients Gx = P(x+1,y)-P(x,y) and Gy = P(x,y+1)-P(x,y) using a one-row line buffer instead of a full-frame array.
- Writes packed {Gx,Gy} to gradient memory, one result per cycle. Sits between the image RAM and the gradient RAM; started by the host controller.

Parameters:
- IMG_W, 256, pixels per row (>=2)
- IMG_H, 256, rows per frame (>=2)
- PIX_W, 8, pixel width in bits
- ADDR_W, 16, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- Derived, not overridable: CW = PIX_W+2 (signed component width); GW = 2*CW

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high while a frame is in progress
- done  out  1  high from the frame's completion until the next accepted start
- img_rd  out  1  image read strobe
- img_addr  out  ADDR_W  image read address, raster order
- img_di  in  PIX_W  read data; valid the cycle after img_rd/img_addr are presented
- grad_wr  out  1  gradient write strobe
- grad_addr  out  ADDR_W  gradient write address = raster index of the pixel
- grad_do  out  GW  {Gx[CW-1:0], Gy[CW-1:0]}, two's complement

Behaviour:
- Reset (async): state IDLE; busy, done, img_rd, grad_wr = 0; img_addr, grad_addr, grad_do = 0; counters and line buffer cleared. Reset asserted mid-frame aborts the frame immediately; no further writes occur.
- FSM states: IDLE, READ, FLUSH, DONE.
- IDLE -> READ on start. busy=1 from the next cycle. done clears.
- READ: img_rd=1 for IMG_W*IMG_H consecutive cycles with img_addr = 0,1,...,IMG_W*IMG_H-1. Then img_rd=0 and the FSM moves to FLUSH.
- Pixel sampling: the pixel for address a is sampled one cycle after a is presented and shifted into an IMG_W-deep shift register (line buffer).
- Result emission during READ: when pixel n (n >= IMG_W) is sampled, the block emits the result for index m = n-IMG_W on the next cycle, registered.
  - Gx = buf[m+1] - buf[m]
  - Gy = P(n) - buf[m]
- FLUSH: emits indices (IMG_H-1)*IMG_W .. IMG_W*IMG_H-1 with Gy=0, one per cycle, with no bubble after the READ-phase writes. Then -> DONE.
- Write stream: exactly IMG_W*IMG_H grad_wr cycles, contiguous, with grad_addr strictly incrementing from 0.
- Latency: the first grad_wr (addr 0) is asserted 2 cycles after the cycle presenting img_addr=IMG_W.
- Borders:
  - x = IMG_W-1: Gx = 0 (no wrap into the next row).
  - y = IMG_H-1: Gy = 0.
- Arithmetic: operands zero-extended to CW bits, subtraction in CW-bit signed arithmetic. Range is ±(2^PIX_W-1), so no overflow or saturation is possible.
- DONE: busy=0, done=1 held; the FSM returns to IDLE in the same cycle. done stays high until the next start is accepted.
- start while busy is ignored and has no effect on addresses or counts.
- start in the same cycle as the last write is ignored. start on the cycle after DONE begins a new frame.

Optional Feature:
- Macro: IMG_GRAD_MAG_EN.
- With the macro defined:
  - Extra output port grad_mag, out, PIX_W+1 bits, = |Gx|+|Gy| saturated to 2^(PIX_W+1)-1.
  - grad_mag is registered and aligned with grad_wr/grad_do. Reset value 0.
- Without the macro: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- 4x3 frame (IMG_W=4, IMG_H=3), P = 10*y + x -> 12 writes, addr 0..11, contiguous.
  - Gx = 1 for x<3, 0 at x=3.
  - Gy = 10 for y<2, 0 at y=2.
  - grad_do(addr 0) = {10'd1, 10'd10} = 20'h0040A.
- Constant image 0x80 -> all grad_do = 0. done rises the cycle after write 11 and busy falls. A second start produces an identical stream.
- Extremes: P(0,0)=255, all others 0 -> addr 0 Gx = Gy = -255, grad_do = {10'h301, 10'h301}. With IMG_GRAD_MAG_EN, grad_mag = 9'd510.
- Latency check: record the cycle img_addr=4 is presented -> grad_wr with grad_addr=0 appears exactly 2 cycles later. No bubble between addr 7 and addr 8 at the READ/FLUSH boundary.
- Reset asserted while grad_addr=5:
  - Next cycle: grad_wr, img_rd, busy, done = 0.
  - No further writes.
  - A fresh start then replays addr 0..11 correctly.
- start pulsed mid-frame -> ignored. Write count stays 12, and img_addr does not restart.
